// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the decode-stage register file and its pending-write
//   scoreboard.
//
//   Contents:
//     XLEN_DEF, NREG_DEF - default register width and register count
//     clr_state_t        - bulk-clear FSM state encoding (ST_IDLE, ST_CLEAR)
//     is_zero_addr()     - true when an address hits a hardwired-zero register 0
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Register 0 only behaves as a constant when the zero-register option is on.
    function automatic logic is_zero_addr(input logic zero_en, input logic addr_is_0);
        return zero_en && addr_is_0;
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_sb_bits.sv
// ---------------------------------------------------------------------------
// regfile_sb_bits
//   One pending-write bit per architectural register. A bit is set when an
//   instruction with that destination issues and cleared when its write-back
//   lands. A separate flush port lets the bulk-clear engine zero one bit per
//   cycle.
//
//   Ports:
//     clk, rst            - clock, asynchronous active-low reset
//     clr_en, clr_idx     - write-back completion: clear bit clr_idx
//     set_en, set_idx     - issue: set bit set_idx (wins over clr on same index)
//     flush_en, flush_idx - bulk-clear step: clear bit flush_idx
//     rd_a1, rd_a2        - read tap addresses
//     tap1, tap2          - raw pending bits at rd_a1 / rd_a2
// ---------------------------------------------------------------------------
module regfile_sb_bits
    import regfile_pkg::*;
#(
    parameter  int NREG     = NREG_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          flush_en,
    input  logic [AW-1:0] flush_idx,
    input  logic [AW-1:0] rd_a1,
    input  logic [AW-1:0] rd_a2,
    output logic          tap1,
    output logic          tap2
);

    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Order matters: the set is applied last so that an instruction issuing to
    // the same destination that is retiring this cycle keeps the bit pending
    // for the younger writer.
    always_comb begin
        busy_d = busy_q;
        if (flush_en) begin
            busy_d[flush_idx] = 1'b0;
        end
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en && !is_zero_addr(ZERO_EN, set_idx == '0)) begin
            busy_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign tap1 = busy_q[rd_a1];
    assign tap2 = busy_q[rd_a2];

endmodule : regfile_sb_bits

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Decode-stage integer register file: two combinational read ports, one
//   write port from WB with same-cycle write-to-read bypass, optional
//   hardwired-zero register 0, a per-register pending-write scoreboard for the
//   hazard unit, and a sequential bulk-clear engine that zeroes one array entry
//   and one scoreboard bit per cycle.
//
//   Ports:
//     clk, rst             - clock, asynchronous active-low reset
//     A1/RD1, A2/RD2       - read address / read data, ports 1 and 2
//     WE3, A3, WD3         - write enable, address, data (WB stage)
//     ISSUE_EN, ISSUE_RD   - instruction with destination ISSUE_RD is issuing
//     BUSY1, BUSY2         - register at A1 / A2 has a pending write
//     CLR_REQ              - start bulk clear (level, sampled while idle)
//     CLR_BUSY             - bulk clear in progress
//     CLR_DONE             - one-cycle pulse after the last entry is cleared
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            ISSUE_EN,
    input  logic [AW-1:0]   ISSUE_RD,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic            CLR_REQ,
    output logic            CLR_BUSY,
    output logic            CLR_DONE
);

    localparam logic          ZERO_EN = (ZERO_REG != 0);
    localparam logic [AW-1:0] LAST    = AW'(NREG - 1);

    clr_state_t      state_q;
    clr_state_t      state_d;
    logic [AW-1:0]   cnt_q;
    logic            done_q;

    logic            clr_busy;
    logic            clr_last;

    logic [XLEN-1:0] regs [NREG];

    logic            we_idle;
    logic            wr_en;
    logic            issue_idle;
    logic            tap1;
    logic            tap2;
    logic [XLEN-1:0] rd1_val;
    logic [XLEN-1:0] rd2_val;

    // -----------------------------------------------------------------------
    // Bulk-clear FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bulk-clear FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (CLR_REQ)        state_d = ST_CLEAR;
            ST_CLEAR: if (cnt_q == LAST)  state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Bulk-clear FSM: outputs
    always_comb begin
        clr_busy = (state_q == ST_CLEAR);
        clr_last = (state_q == ST_CLEAR) && (cnt_q == LAST);
    end

    // Sweep counter and the completion pulse. The counter is held at zero while
    // idle so every clear starts from entry 0, and it returns to zero right
    // after the last entry instead of running past NREG-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= clr_last;
            if (clr_busy && !clr_last) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign CLR_BUSY = clr_busy;
    assign CLR_DONE = done_q;

    // -----------------------------------------------------------------------
    // Register array
    // -----------------------------------------------------------------------
    // WB writes and issues are only honoured while idle; during a sweep they
    // are dropped so the array ends up fully zeroed.
    assign we_idle    = WE3 && !clr_busy;
    assign issue_idle = ISSUE_EN && !clr_busy;
    assign wr_en      = we_idle && !is_zero_addr(ZERO_EN, A3 == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_busy) begin
            regs[cnt_q] <= '0;
        end else if (wr_en) begin
            regs[A3] <= WD3;
        end
    end

    // Read ports: zero register beats bypass, bypass beats the array. Outputs
    // are forced to zero while reset is held so that a live WB bypass cannot
    // leak through during reset.
    always_comb begin
        rd1_val = regs[A1];
        if (we_idle && (A3 == A1)) rd1_val = WD3;
        if (is_zero_addr(ZERO_EN, A1 == '0)) rd1_val = '0;
        if (!rst) rd1_val = '0;
    end

    always_comb begin
        rd2_val = regs[A2];
        if (we_idle && (A3 == A2)) rd2_val = WD3;
        if (is_zero_addr(ZERO_EN, A2 == '0)) rd2_val = '0;
        if (!rst) rd2_val = '0;
    end

    assign RD1 = rd1_val;
    assign RD2 = rd2_val;

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
    regfile_sb_bits #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .clr_en    (we_idle),
        .clr_idx   (A3),
        .set_en    (issue_idle),
        .set_idx   (ISSUE_RD),
        .flush_en  (clr_busy),
        .flush_idx (cnt_q),
        .rd_a1     (A1),
        .rd_a2     (A2),
        .tap1      (tap1),
        .tap2      (tap2)
    );

    // A write landing this cycle is already visible through the bypass, so it
    // no longer counts as a hazard for that address.
    always_comb begin
        BUSY1 = rst && !clr_busy && tap1 && !(we_idle && (A3 == A1))
                && !is_zero_addr(ZERO_EN, A1 == '0);
        BUSY2 = rst && !clr_busy && tap2 && !(we_idle && (A3 == A2))
                && !is_zero_addr(ZERO_EN, A2 == '0);
    end

endmodule : regfile_scoreboard

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's integer register file: configurable width and depth, 2 async read ports, 1 write port.
- Adds three things:
  - same-cycle write-to-read bypass;
  - optional hardwired-zero register 0;
  - per-register pending-write scoreboard for hazard detection in decode.
- Also provides a sequential bulk-clear engine that zeroes the array and scoreboard one entry per cycle.
- Sits in decode: reads feed ID/EX, the write port is driven from WB, and issue/busy signals go to the hazard unit.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers (power of two, ≥2).
- AW, $clog2(NREG), address width (derived, not overridden).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and issue.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- RD1  out  XLEN  read data, port 1.
- RD2  out  XLEN  read data, port 2.
- WE3  in  1  write enable (WB stage).
- A3  in  AW  write address.
- WD3  in  XLEN  write data.
- ISSUE_EN  in  1  instruction with a destination is issuing.
- ISSUE_RD  in  AW  destination of the issuing instruction.
- BUSY1  out  1  register A1 has a pending write not yet available.
- BUSY2  out  1  register A2 has a pending write not yet available.
- CLR_REQ  in  1  start bulk clear (level, sampled in IDLE).
- CLR_BUSY  out  1  clear in progress.
- CLR_DONE  out  1  one-cycle pulse after the last entry is cleared.

Behaviour:
- Reset (rst=0, async):
  - all registers = 0; busy vector = 0; FSM = IDLE; counter = 0.
  - CLR_BUSY = 0, CLR_DONE = 0.
  - RD1/RD2 = 0 and BUSY1/2 = 0 while reset is held.
- Write: at posedge, if WE3 && state==IDLE && !(ZERO_REG && A3==0), then reg[A3] <= WD3.
- Read (combinational, 0 latency):
  - RDn = 0 if ZERO_REG && An==0.
  - else RDn = WD3 if WE3 && A3==An && state==IDLE (bypass).
  - else RDn = reg[An].
- Scoreboard, one busy bit per register:
  - posedge, IDLE: if WE3, clear busy[A3].
  - If ISSUE_EN, set busy[ISSUE_RD].
  - Same index for both: set wins, because the younger writer is still pending.
  - Index 0 is never set when ZERO_REG=1.
- BUSYn = busy[An] && !(WE3 && A3==An). Bypass covers the write in flight.
  - BUSYn = 0 for An==0 when ZERO_REG=1.
  - BUSYn = 0 whenever CLR_BUSY=1.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when CLR_REQ=1; counter <= 0.
  - CLEAR, each cycle: reg[counter] <= 0; busy[counter] <= 0; counter++.
  - When counter==NREG-1, that entry is cleared, state → IDLE, and CLR_DONE = 1 the following cycle.
  - Total: exactly NREG cycles with CLR_BUSY=1.
  - During CLEAR, WE3 and ISSUE_EN are ignored (dropped); RDn return array contents with no bypass.
  - CLR_REQ held high after completion starts a new clear from the next IDLE cycle.
  - Counter width is AW; no wrap beyond NREG-1.
- Reset mid-clear: immediate return to IDLE with everything zeroed; no CLR_DONE.
- Simultaneous A1==A2: both ports return identical data and busy.

Decomposition:
- Shared package regfile_pkg holds:
  - FSM state encoding (ST_IDLE, ST_CLEAR);
  - defaults XLEN_DEF=32, NREG_DEF=32.
- One natural sub-module: regfile_sb_bits, the NREG-bit scoreboard with set/clear/flush and the two busy read taps.
- Array, bypass and clear FSM stay in the top module.

Test Plan:
- Reset then read all 32 addresses → RD1=RD2=0, BUSY1/2=0; write A3=5, WD3=0xDEADBEEF → next cycle A1=5 gives RD1=0xDEADBEEF.
- Same-cycle bypass: WE3=1, A3=7, WD3=0x12345678, A2=7 in the same cycle → RD2=0x12345678 combinationally and BUSY2=0.
- Zero register: write A3=0, WD3=0xFFFFFFFF, and ISSUE_RD=0 → RD1(A1=0)=0, BUSY1=0.
- Scoreboard:
  - ISSUE_EN with ISSUE_RD=9 → BUSY1(A1=9)=1 next cycle.
  - WE3 A3=9 plus ISSUE_RD=9 in the same cycle → busy remains set.
  - A later WE3 A3=9 alone → BUSY1=0.
- Bulk clear:
  - Preload regs 1..31 with nonzero values, pulse CLR_REQ → CLR_BUSY high exactly 32 cycles, then a CLR_DONE pulse, then all reads 0.
  - A WE3 to reg 3 during the clear is dropped → reg 3 reads 0.
- Reset mid-clear: assert rst=0 at cycle 10 of the clear → CLR_BUSY=0 immediately, no CLR_DONE, all registers 0, and normal writes work after release.
